cam_frame_writer: RTL and testbench

// - Parametrised camera-side capture engine: pairs 8-bit sensor bytes into RGB565 pixels,

---
 rtl/cam_frame_writer_if.sv | 31 +++
 rtl/cam_frame_writer.sv | 189 ++++++++++++++++++
 tb/tb_cam_frame_writer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cam_frame_writer_if.sv
// Camera capture bus: sensor-side inputs and frame-buffer write port of cam_frame_writer.
interface cam_frame_writer_if #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned SEL_W  = 4,
   parameter int unsigned FCNT_W = 8
);
   logic              href;
   logic              vsync;
   logic [7:0]        cam_data;
   logic [SEL_W-1:0]  sel;
   logic              we;
   logic [ADDR_W-1:0] wAddr;
   logic [15:0]       wData;
   logic [SEL_W-1:0]  sel_frame;
   logic              frame_start;
   logic              frame_done;
   logic [FCNT_W-1:0] frame_cnt;
   logic              line_err;

   // Capture engine side
   modport slave (
      input  href, vsync, cam_data, sel,
      output we, wAddr, wData, sel_frame, frame_start, frame_done, frame_cnt, line_err
   );

   // Sensor / frame-buffer side
   modport master (
      output href, vsync, cam_data, sel,
      input  we, wAddr, wData, sel_frame, frame_start, frame_done, frame_cnt, line_err
   );
endinterface

// File: rtl/cam_frame_writer.sv
// Camera capture engine: pairs sensor bytes into RGB565 pixels, optional 2x/4x
// decimation, linear frame-buffer write address, frame-latched filter select.
// Optional feature macro: CAM_LINE_CHECK_EN (line/frame length checker on line_err).
module cam_frame_writer #(
   parameter int unsigned H_ACTIVE = 320,
   parameter int unsigned V_ACTIVE = 240,
   parameter int unsigned DEC_LOG2 = 0,
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned SEL_W    = 4,
   parameter int unsigned FCNT_W   = 8
) (
   input logic               clk,
   input logic               reset,
   cam_frame_writer_if.slave bus
);
   // Counters saturate one past the active size so over-long lines stay detectable
   localparam int unsigned COL_W = $clog2(H_ACTIVE + 2);
   localparam int unsigned ROW_W = $clog2(V_ACTIVE + 2);
   localparam int unsigned NPIX  = (H_ACTIVE * V_ACTIVE) >> (2 * DEC_LOG2);

   localparam logic [COL_W-1:0]  H_LIM     = COL_W'(H_ACTIVE);
   localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(H_ACTIVE + 1);
   localparam logic [ROW_W-1:0]  V_LIM     = ROW_W'(V_ACTIVE);
   localparam logic [ROW_W-1:0]  ROW_SAT   = ROW_W'(V_ACTIVE + 1);
   localparam logic [COL_W-1:0]  COL_MASK  = COL_W'((1 << DEC_LOG2) - 1);
   localparam logic [ROW_W-1:0]  ROW_MASK  = ROW_W'((1 << DEC_LOG2) - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);

   localparam logic [1:0] S_SYNC   = 2'd0;
   localparam logic [1:0] S_VBLANK = 2'd1;
   localparam logic [1:0] S_ACTIVE = 2'd2;

   localparam logic PH_HI = 1'b0;
   localparam logic PH_LO = 1'b1;

   logic [1:0]        state_q, state_d;
   logic              phase_q, phase_d;
   logic [7:0]        hi_q, hi_d;
   logic              href_q, href_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [SEL_W-1:0]  sel_frame_q, sel_frame_d;
   logic              fstart_q, fstart_d;
   logic              fdone_q, fdone_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              keep;

   // Frame FSM, byte pairing, decimation and write-address generation
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      hi_d        = hi_q;
      href_d      = 1'b0;
      col_d       = col_q;
      row_d       = row_q;
      cnt_d       = cnt_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      sel_frame_d = sel_frame_q;
      fstart_d    = 1'b0;
      fdone_d     = 1'b0;
      fcnt_d      = fcnt_q;
      keep        = (col_q < H_LIM) && (row_q < V_LIM) &&
                    ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);
      case (state_q)
         S_SYNC: begin
            if (bus.vsync) state_d = S_VBLANK;
         end
         S_VBLANK: begin
            if (!bus.vsync) begin
               state_d     = S_ACTIVE;
               sel_frame_d = bus.sel;
               fstart_d    = 1'b1;
               cnt_d       = '0;
               waddr_d     = '0;
               col_d       = '0;
               row_d       = '0;
               phase_d     = PH_HI;
            end
         end
         S_ACTIVE: begin
            if (bus.vsync) begin
               // vsync wins over href; any half pixel is dropped
               state_d = S_VBLANK;
               fdone_d = 1'b1;
               fcnt_d  = fcnt_q + FCNT_W'(1);
               phase_d = PH_HI;
            end else if (bus.href) begin
               href_d = 1'b1;
               if (phase_q == PH_HI) begin
                  hi_d    = bus.cam_data;
                  phase_d = PH_LO;
               end else begin
                  phase_d = PH_HI;
                  if (keep) begin
                     we_d    = 1'b1;
                     waddr_d = cnt_q;
                     wdata_d = {hi_q, bus.cam_data};
                     if (cnt_q != ADDR_LAST) cnt_d = cnt_q + ADDR_W'(1);
                  end
                  if (col_q != COL_SAT) col_d = col_q + COL_W'(1);
               end
            end else if (href_q) begin
               // End of line: odd trailing byte dropped
               if (row_q != ROW_SAT) row_d = row_q + ROW_W'(1);
               col_d   = '0;
               phase_d = PH_HI;
            end
         end
         default: state_d = S_SYNC;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_SYNC;
         phase_q     <= PH_HI;
         hi_q        <= '0;
         href_q      <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         sel_frame_q <= '0;
         fstart_q    <= 1'b0;
         fdone_q     <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         hi_q        <= hi_d;
         href_q      <= href_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         sel_frame_q <= sel_frame_d;
         fstart_q    <= fstart_d;
         fdone_q     <= fdone_d;
         fcnt_q      <= fcnt_d;
      end
   end

`ifdef CAM_LINE_CHECK_EN
   logic line_err_q, line_err_d;
   logic line_fall;

   // Sticky line/frame length error, cleared at frame start
   always_comb begin
      line_fall  = (state_q == S_ACTIVE) && !bus.vsync && !bus.href && href_q;
      line_err_d = line_err_q;
      if (fstart_d) begin
         line_err_d = 1'b0;
      end else if (line_fall && (col_q != H_LIM)) begin
         line_err_d = 1'b1;
      end else if (fdone_d && (row_q != V_LIM)) begin
         line_err_d = 1'b1;
      end
   end

   // Error flag register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) line_err_q <= 1'b0;
      else        line_err_q <= line_err_d;
   end

   assign bus.line_err = line_err_q;
`else
   assign bus.line_err = 1'b0;
`endif

   assign bus.we          = we_q;
   assign bus.wAddr       = waddr_q;
   assign bus.wData       = wdata_q;
   assign bus.sel_frame   = sel_frame_q;
   assign bus.frame_start = fstart_q;
   assign bus.frame_done  = fdone_q;
   assign bus.frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer: instance A (H=4,V=2,no decimation) and
// instance B (H=8,V=4,2x decimation) share clock, reset and sensor inputs.
module tb_cam_frame_writer;
   logic       clk;
   logic       rst_n;
   logic       href;
   logic       vsync;
   logic [7:0] cam_data;
   logic [3:0] sel;

   int n_chk = 0;
   int n_bad = 0;
   int bk    = 0;

   cam_frame_writer_if #(.ADDR_W(4), .SEL_W(4), .FCNT_W(8)) ifa ();
   cam_frame_writer_if #(.ADDR_W(4), .SEL_W(4), .FCNT_W(8)) ifb ();

   assign ifa.href = href;  assign ifa.vsync = vsync;  assign ifa.cam_data = cam_data;  assign ifa.sel = sel;
   assign ifb.href = href;  assign ifb.vsync = vsync;  assign ifb.cam_data = cam_data;  assign ifb.sel = sel;

   cam_frame_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .DEC_LOG2(0), .ADDR_W(4), .SEL_W(4), .FCNT_W(8))
      u_dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
   cam_frame_writer #(.H_ACTIVE(8), .V_ACTIVE(4), .DEC_LOG2(1), .ADDR_W(4), .SEL_W(4), .FCNT_W(8))
      u_dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write/pulse monitor, sampled on the falling edge
   int          wr_a = 0, seq_a = 0, done_a = 0, fs_a = 0, idx_a = 0;
   int          wr_b = 0, seq_b = 0, idx_b = 0;
   logic [15:0] data_a [64];
   logic [15:0] data_b [64];

   always @(negedge clk) begin
      if (ifa.frame_start) begin idx_a = 0; fs_a++; end
      if (ifa.frame_done) done_a++;
      if (ifa.we) begin
         if (32'(ifa.wAddr) != idx_a) seq_a++;
         if (idx_a < 64) data_a[idx_a] = ifa.wData;
         idx_a++;
         wr_a++;
      end
      if (ifb.frame_start) idx_b = 0;
      if (ifb.we) begin
         if (32'(ifb.wAddr) != idx_b) seq_b++;
         if (idx_b < 64) data_b[idx_b] = ifb.wData;
         idx_b++;
         wr_b++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input int k);
      return 8'(18 + k * 34);
   endfunction

   function automatic logic [15:0] pix_at(input int i);
      return {byte_at(2 * i), byte_at(2 * i + 1)};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic put(input logic h, input logic [7:0] d);
      href = h; cam_data = d;
      @(negedge clk);
   endtask

   task automatic vblank();
      href = 1'b0; vsync = 1'b1; tick(3);
      vsync = 1'b0; bk = 0; tick(2);
   endtask

   task automatic end_frame();
      href = 1'b0; vsync = 1'b1; tick(2);
   endtask

   // mode 0: running byte sequence; mode 1: ramp pixel {row, col}
   task automatic send_line(input int npix, input int extra, input int mode, input int r);
      for (int c = 0; c < npix; c++) begin
         if (mode == 0) begin
            put(1'b1, byte_at(bk)); put(1'b1, byte_at(bk + 1)); bk += 2;
         end else begin
            put(1'b1, 8'(r)); put(1'b1, 8'(c));
         end
      end
      for (int e = 0; e < extra; e++) put(1'b1, 8'hEE);
      href = 1'b0; cam_data = 8'h00;
      tick(2);
   endtask

   int w0, s0, d0, sb0, exp_le;

   initial begin
      rst_n = 1'b0; href = 1'b0; vsync = 1'b0; cam_data = 8'h00; sel = 4'd0;
      tick(2);
      chk("rst_we", 32'(ifa.we), 0);
      chk("rst_waddr", 32'(ifa.wAddr), 0);
      chk("rst_wdata", 32'(ifa.wData), 0);
      chk("rst_fcnt", 32'(ifa.frame_cnt), 0);
      chk("rst_fstart", 32'(ifa.frame_start), 0);
      chk("rst_line_err", 32'(ifa.line_err), 0);
      rst_n = 1'b1;
      tick(1);

      // 4x2 frame, byte sequence 0x12,0x34,...
      w0 = wr_a; s0 = seq_a; d0 = done_a;
      vblank();
      for (int k = 0; k < 8; k++) begin
         put(1'b1, byte_at(k));
         if (k == 0) chk("we_after_hi", 32'(ifa.we), 0);
         if (k == 1) begin
            chk("we_after_lo", 32'(ifa.we), 1);
            chk("first_wdata", 32'(ifa.wData), 32'h1234);
            chk("first_waddr", 32'(ifa.wAddr), 0);
         end
      end
      bk = 8;
      href = 1'b0; tick(2);
      send_line(4, 0, 0, 1);
      end_frame(); tick(1);
      chk("f1_writes", 32'(wr_a - w0), 8);
      chk("f1_addr_seq", 32'(seq_a - s0), 0);
      chk("f1_done_cnt", 32'(done_a - d0), 1);
      chk("f1_fcnt", 32'(ifa.frame_cnt), 1);
      for (int i = 0; i < 8; i++) chk($sformatf("f1_pix%0d", i), 32'(data_a[i]), 32'(pix_at(i)));

      // 2x decimation on B with ramp frame
      w0 = wr_b; sb0 = seq_b;
      vblank();
      for (int r = 0; r < 4; r++) send_line(8, 0, 1, r);
      end_frame(); tick(1);
      chk("dec_writes", 32'(wr_b - w0), 8);
      chk("dec_addr_seq", 32'(seq_b - sb0), 0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("dec_pix%0d", i), 32'(data_b[i]), 32'({8'(2 * (i / 4)), 8'(2 * (i % 4))}));

      // Filter select latched only at frame start
      sel = 4'd3;
      vblank();
      sel = 4'd7;
      send_line(4, 0, 0, 0);
      chk("sel_mid", 32'(ifa.sel_frame), 3);
      send_line(4, 0, 0, 1);
      end_frame();
      chk("sel_blank", 32'(ifa.sel_frame), 3);
      vblank();
      chk("sel_next", 32'(ifa.sel_frame), 7);

      // Async reset mid-line, released with vsync low
      send_line(4, 0, 0, 0);
      put(1'b1, 8'hAA); put(1'b1, 8'hBB);
      #1 rst_n = 1'b0;
      #1 chk("rst_async_fcnt", 32'(ifa.frame_cnt), 0);
      chk("rst_async_sel", 32'(ifa.sel_frame), 0);
      @(negedge clk);
      rst_n = 1'b1;
      w0 = wr_a;
      send_line(4, 0, 0, 0);
      send_line(4, 0, 0, 1);
      tick(1);
      chk("rst_no_writes", 32'(wr_a - w0), 0);
      end_frame();
      w0 = wr_a; s0 = seq_a;
      vblank();
      send_line(4, 0, 0, 0);
      send_line(4, 0, 0, 1);
      end_frame(); tick(1);
      chk("rst_resume_writes", 32'(wr_a - w0), 8);
      chk("rst_resume_seq", 32'(seq_a - s0), 0);
      chk("rst_resume_fcnt", 32'(ifa.frame_cnt), 1);

      // Short line
`ifdef CAM_LINE_CHECK_EN
      exp_le = 1;
`else
      exp_le = 0;
`endif
      vblank();
      send_line(3, 0, 0, 0);
      chk("le_short_line", 32'(ifa.line_err), 32'(exp_le));
      send_line(4, 0, 0, 1);
      end_frame();
      chk("le_held_blank", 32'(ifa.line_err), 32'(exp_le));
      vblank();
      chk("le_cleared", 32'(ifa.line_err), 0);
      send_line(4, 0, 0, 0);
      send_line(4, 0, 0, 1);
      end_frame();
      chk("le_good_frame", 32'(ifa.line_err), 0);

      // Frame counter wrap with 5 surplus bytes per line
      rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
      w0 = wr_a; s0 = seq_a; d0 = done_a;
      for (int f = 0; f < 255; f++) begin
         vblank();
         send_line(4, 5, 0, 0);
         send_line(4, 5, 0, 1);
         end_frame();
      end
      chk("wrap_fcnt_255", 32'(ifa.frame_cnt), 255);
      vblank();
      send_line(4, 5, 0, 0);
      send_line(4, 5, 0, 1);
      end_frame(); tick(1);
      chk("wrap_fcnt_0", 32'(ifa.frame_cnt), 0);
      chk("wrap_writes", 32'(wr_a - w0), 256 * 8);
      chk("wrap_addr_seq", 32'(seq_a - s0), 0);
      chk("wrap_done_cnt", 32'(done_a - d0), 256);
      chk("wrap_pix4", 32'(data_a[4]), 32'(pix_at(4)));
      chk("wrap_pix7", 32'(data_a[7]), 32'(pix_at(7)));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
